// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; produces {HI=remainder, LO=quotient}
// and holds the pipeline while a divide is in flight.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_signed_div,
  input  logic [WIDTH-1:0]   i_opdata1,
  input  logic [WIDTH-1:0]   i_opdata2,
  input  logic               i_annul,
  output logic [2*WIDTH-1:0] o_result,
  output logic               o_ready,
  output logic               o_stall
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t           r_state, w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem, r_quo, r_div;
  logic             r_neg_q, r_neg_r;
  logic             w_go;
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_rem_fix, w_quo_fix;
  logic [WIDTH:0]   w_trial;

  assign w_go    = i_start & ~i_annul;
  assign w_a_mag = (i_signed_div & i_opdata1[WIDTH-1]) ? -i_opdata1 : i_opdata1;
  assign w_b_mag = (i_signed_div & i_opdata2[WIDTH-1]) ? -i_opdata2 : i_opdata2;

  // Shifted partial remainder can need WIDTH+1 bits; the trial MSB is the borrow.
  assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
  assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
  assign w_quo_fix = r_neg_q ? -r_quo : r_quo;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_go) w_next = (i_opdata2 == '0) ? S_DIVZERO : S_ON;
      S_DIVZERO: w_next = i_annul ? S_IDLE : S_END;
      S_ON: begin
        if (i_annul)                         w_next = S_IDLE;
        else if (r_cnt == CW'(WIDTH - 1))    w_next = S_END;
      end
      S_END:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready  = 1'b0;
    o_stall  = 1'b0;
    o_result = '0;
    case (r_state)
      S_IDLE:          o_stall = w_go;
      S_DIVZERO, S_ON: o_stall = 1'b1;
      S_END: if (!i_annul) begin
        o_ready  = 1'b1;
        o_result = {w_rem_fix, w_quo_fix};
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_go) begin
          r_cnt <= '0;
          if (i_opdata2 == '0) begin
            // Divide-by-zero result is staged directly with no sign fix-up.
            r_rem   <= i_opdata1;
            r_quo   <= '1;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
          end else begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_neg_q <= i_signed_div & (i_opdata1[WIDTH-1] ^ i_opdata2[WIDTH-1]);
            r_neg_r <= i_signed_div & i_opdata1[WIDTH-1];
          end
        end
        S_ON: if (!i_annul) begin
          r_cnt <= r_cnt + CW'(1);
          r_rem <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
          r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed spec cases plus randomized divides
// against an arithmetic reference model.
module tb_div_unit;
  logic        i_clk = 1'b0;
  logic        i_rst, i_start, i_signed_div, i_annul;
  logic [31:0] i_opdata1, i_opdata2;
  logic [63:0] o_result;
  logic        o_ready, o_stall;

  int n_tests = 0;
  int n_fail  = 0;

  div_unit #(.WIDTH(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_signed_div(i_signed_div),
    .i_opdata1(i_opdata1), .i_opdata2(i_opdata2), .i_annul(i_annul),
    .o_result(o_result), .o_ready(o_ready), .o_stall(o_stall)
  );

  always #5 i_clk = ~i_clk;

  // Reference: language division truncates toward zero, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint q, r;
    logic [63:0] qv, rv;
    if (b == 32'd0) return {a, 32'hFFFFFFFF};
    if (sgn) begin
      q = longint'($signed(a)) / longint'($signed(b));
      r = longint'($signed(a)) % longint'($signed(b));
    end else begin
      q = longint'({32'd0, a}) / longint'({32'd0, b});
      r = longint'({32'd0, a}) % longint'({32'd0, b});
    end
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Starts one divide at cycle 0 (called just after a rising edge) and observes 60 cycles.
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output int rdy_cyc, output int rdy_cnt, output logic [63:0] res,
                         output int stall_cnt, output int stall_last, output int bad_res);
    i_start = 1'b1; i_signed_div = sgn; i_opdata1 = a; i_opdata2 = b; i_annul = 1'b0;
    rdy_cyc = -1; rdy_cnt = 0; res = '0; stall_cnt = 0; stall_last = -1; bad_res = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge i_clk);
      if (o_stall) begin stall_cnt++; stall_last = c; end
      if (o_ready) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin rdy_cyc = c; res = o_result; end
      end else if (o_result !== 64'd0) bad_res++;
      @(posedge i_clk); #1;
      i_start = 1'b0;
      i_opdata1 = $urandom; i_opdata2 = $urandom; i_signed_div = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    i_rst = 1'b1; i_start = 1'b0; i_signed_div = 1'b0; i_annul = 1'b0;
    i_opdata1 = '0; i_opdata2 = '0;
    #3;
    n_tests++;
    if ({o_ready, o_stall, o_result} !== 66'd0) begin
      n_fail++; $display("FAIL reset_outputs: got ready=%b stall=%b result=%h want all 0", o_ready, o_stall, o_result);
    end
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
  endtask

  task automatic test_unsigned_basic;
    int rc, rn, sc, sl, br;
    logic [63:0] res;
    run_div(1'b0, 32'd100, 32'd7, rc, rn, res, sc, sl, br);
    n_tests++;
    if (rc !== 33 || rn !== 1) begin n_fail++; $display("FAIL u100_7_latency: got cycle=%0d pulses=%0d want cycle=33 pulses=1", rc, rn); end
    n_tests++;
    if (res !== {32'd2, 32'd14}) begin n_fail++; $display("FAIL u100_7_result: got %h want %h", res, {32'd2, 32'd14}); end
    n_tests++;
    if (sc !== 33 || sl !== 32) begin n_fail++; $display("FAIL u100_7_stall: got count=%0d last=%0d want count=33 last=32", sc, sl); end
    n_tests++;
    if (br !== 0) begin n_fail++; $display("FAIL u100_7_idle_result: got %0d nonzero cycles want 0", br); end
  endtask

  task automatic test_signed;
    int rc, rn, sc, sl, br;
    logic [63:0] res;
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'hFFFFFFFF, 32'hFFFFFFFD} || rc !== 33) begin
      n_fail++; $display("FAIL s_m7_2: got %h at %0d want %h at 33", res, rc, {32'hFFFFFFFF, 32'hFFFFFFFD});
    end
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'h00000001, 32'hFFFFFFFD} || rc !== 33) begin
      n_fail++; $display("FAIL s_7_m2: got %h at %0d want %h at 33", res, rc, {32'h00000001, 32'hFFFFFFFD});
    end
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'h00000000, 32'h80000000}) begin
      n_fail++; $display("FAIL s_overflow: got %h want %h", res, {32'h00000000, 32'h80000000});
    end
    run_div(1'b0, 32'hFFFFFFFF, 32'd1, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'h00000000, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL u_max_1: got %h want %h", res, {32'h00000000, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_divzero;
    int rc, rn, sc, sl, br;
    logic [63:0] res;
    run_div(1'b0, 32'h12345678, 32'd0, rc, rn, res, sc, sl, br);
    n_tests++;
    if (rc !== 2 || rn !== 1) begin n_fail++; $display("FAIL dz_latency: got cycle=%0d pulses=%0d want cycle=2 pulses=1", rc, rn); end
    n_tests++;
    if (res !== {32'h12345678, 32'hFFFFFFFF}) begin n_fail++; $display("FAIL dz_result: got %h want %h", res, {32'h12345678, 32'hFFFFFFFF}); end
    n_tests++;
    if (sc !== 2 || sl !== 1) begin n_fail++; $display("FAIL dz_stall: got count=%0d last=%0d want count=2 last=1", sc, sl); end
    run_div(1'b1, 32'hCAFEF00D, 32'd0, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'hCAFEF00D, 32'hFFFFFFFF} || rc !== 2) begin
      n_fail++; $display("FAIL dz_signed: got %h at %0d want %h at 2", res, rc, {32'hCAFEF00D, 32'hFFFFFFFF});
    end
  endtask

  task automatic test_random;
    int rc, rn, sc, sl, br;
    logic [63:0] res, exp;
    logic [31:0] a, b;
    bit sgn;
    for (int k = 0; k < 24; k++) begin
      sgn = 1'(k);
      a = $urandom;
      case (k % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'hFFFFFFFF - $urandom_range(0, 15);
        default: b = (k == 7) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      endcase
      exp = ref_div(sgn, a, b);
      run_div(sgn, a, b, rc, rn, res, sc, sl, br);
      n_tests++;
      if (res !== exp || rc !== ((b == 0) ? 2 : 33) || rn !== 1 || br !== 0) begin
        n_fail++;
        $display("FAIL rand_%0d: s=%0d %h/%h got %h at %0d (%0d pulses) want %h", k, sgn, a, b, res, rc, rn, exp);
      end
    end
  endtask

  task automatic test_back_to_back;
    int r1 = -1, r2 = -1, extra = 0;
    logic [63:0] res1 = '0, res2 = '0;
    logic s33 = 1'bx;
    i_start = 1'b1; i_signed_div = 1'b0; i_opdata1 = 32'hFFFFFFFF; i_opdata2 = 32'd1; i_annul = 1'b0;
    for (int c = 0; c <= 70; c++) begin
      @(negedge i_clk);
      if (c == 33) s33 = o_stall;
      if (o_ready) begin
        if (r1 < 0)      begin r1 = c; res1 = o_result; end
        else if (r2 < 0) begin r2 = c; res2 = o_result; end
        else extra++;
      end
      @(posedge i_clk); #1;
      i_start = (c + 1 <= 67);
    end
    n_tests++;
    if (r1 !== 33 || r2 !== 67 || extra !== 0) begin
      n_fail++; $display("FAIL b2b_timing: got %0d,%0d extra=%0d want 33,67 extra=0", r1, r2, extra);
    end
    n_tests++;
    if (res1 !== {32'd0, 32'hFFFFFFFF} || res2 !== {32'd0, 32'hFFFFFFFF}) begin
      n_fail++; $display("FAIL b2b_result: got %h,%h want %h", res1, res2, {32'd0, 32'hFFFFFFFF});
    end
    n_tests++;
    if (s33 !== 1'b0) begin n_fail++; $display("FAIL b2b_end_stall: got %b want 0", s33); end
  endtask

  task automatic test_annul;
    int rc, rn, sc, sl, br, bad_rdy, bad_stall, acyc, quiet;
    logic [63:0] res, exp;
    logic [31:0] a, b;
    for (int s = 0; s < 4; s++) begin
      acyc  = (s == 0) ? 10 : (s == 1) ? 33 : (s == 2) ? 1 : 0;
      quiet = (s == 0) ? 11 : (s == 1) ? 34 : (s == 2) ? 2 : 0;
      bad_rdy = 0; bad_stall = 0;
      i_start = 1'b1; i_signed_div = 1'b0; i_opdata1 = $urandom;
      i_opdata2 = (s == 2) ? 32'd0 : ($urandom | 32'd1);
      i_annul = (acyc == 0);
      for (int c = 0; c <= 40; c++) begin
        @(negedge i_clk);
        if (o_ready) bad_rdy++;
        if (c >= quiet && o_stall) bad_stall++;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_annul = (c + 1 == acyc);
      end
      n_tests++;
      if (bad_rdy !== 0 || bad_stall !== 0) begin
        n_fail++; $display("FAIL annul_%0d: got ready_cycles=%0d stall_cycles=%0d want 0,0", s, bad_rdy, bad_stall);
      end
      a = $urandom; b = $urandom_range(1, 1000);
      exp = ref_div(1'b1, a, b);
      run_div(1'b1, a, b, rc, rn, res, sc, sl, br);
      n_tests++;
      if (res !== exp || rc !== 33) begin
        n_fail++; $display("FAIL annul_recover_%0d: got %h at %0d want %h at 33", s, res, rc, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    int rc, rn, sc, sl, br;
    logic [63:0] res;
    logic pre_stall;
    i_start = 1'b1; i_signed_div = 1'b0; i_opdata1 = 32'd100; i_opdata2 = 32'd7; i_annul = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
    end
    #1;
    pre_stall = o_stall;
    i_rst = 1'b1;
    #1;
    n_tests++;
    if (pre_stall !== 1'b1 || {o_ready, o_stall, o_result} !== 66'd0) begin
      n_fail++; $display("FAIL async_reset: got pre_stall=%b ready=%b stall=%b result=%h want 1,0,0,0",
                         pre_stall, o_ready, o_stall, o_result);
    end
    @(negedge i_clk); @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    run_div(1'b0, 32'd100, 32'd7, rc, rn, res, sc, sl, br);
    n_tests++;
    if (res !== {32'd2, 32'd14} || rc !== 33 || sc !== 33 || sl !== 32) begin
      n_fail++; $display("FAIL after_reset: got %h at %0d stall=%0d/%0d want %h at 33 stall=33/32",
                         res, rc, sc, sl, {32'd2, 32'd14});
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_divzero();
    test_random();
    test_back_to_back();
    test_annul();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
